// File: rtl/syn_lifo_fifo.sv
// syn_lifo_fifo: single-clock stack/queue buffer with runtime LIFO/FIFO ordering.
// One storage array serves both modes; only the pointer discipline differs.
// Occupancy, threshold flags and error pulses are registered.
module syn_lifo_fifo #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mode,
    input  logic                           we,
    input  logic                           re,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           dvalid,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           mode_act,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [CW-1:0]    count_nxt;
    logic             push_ok;
    logic             pop_ok;

    // Accept decisions, next occupancy and array addresses for the current mode.
    always_comb begin
        // a push on a full buffer is still accepted when paired with a pop
        push_ok   = we && (!full || re);
        pop_ok    = re && !empty;
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + CW'(1);
        else if (pop_ok && !push_ok)
            count_nxt = count - CW'(1);
        if (mode_act) begin
            waddr = wp;
            raddr = rp;
        end else begin
            // stack pointer is the occupancy; simultaneous push/pop replaces the top slot
            raddr = AW'(count - CW'(1));
            waddr = pop_ok ? raddr : AW'(count);
        end
    end

    // Storage array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem[waddr] <= din;
    end

    // Occupancy, flags, pointers, pop data and mode lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            wp           <= '0;
            rp           <= '0;
            dout         <= '0;
            dvalid       <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            mode_act     <= mode;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_C == '0);
        end else begin
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            overflow     <= we && !re && full;
            underflow    <= re && empty;
            dvalid       <= pop_ok;
            if (pop_ok)
                dout <= mem[raddr];
            if (count == '0 && !push_ok) begin
                mode_act <= mode;
                wp       <= '0;
                rp       <= '0;
            end else if (mode_act) begin
                if (push_ok)
                    wp <= wp + AW'(1);
                if (pop_ok)
                    rp <= rp + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_syn_lifo_fifo.sv
// Directed bench for syn_lifo_fifo with hand-computed expectations.
module tb_syn_lifo_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       mode_act;
    logic       overflow;
    logic       underflow;

    int checks   = 0;
    int failures = 0;

    syn_lifo_fifo #(
        .DEPTH(16),
        .WIDTH(8),
        .AF_LEVEL(14),
        .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .we(we),
        .re(re),
        .din(din),
        .dout(dout),
        .dvalid(dvalid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .mode_act(mode_act),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock with the given request; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        we  = w;
        re  = r;
        din = d;
        @(posedge clk);
        #1;
        we  = 1'b0;
        re  = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        we   = 1'b0;
        re   = 1'b0;
        din  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_dout", dout, 0);
        check("rst_dvalid", dvalid, 0);
        check("rst_mode_act", mode_act, 0);

        // LIFO fill, overflow, drain, underflow
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 12) check("lifo_af_13", almost_full, 0);
            if (i == 13) check("lifo_af_14", almost_full, 1);
        end
        check("lifo_full", full, 1);
        check("lifo_count16", count, 16);
        step(1'b1, 1'b0, 8'd16);
        check("lifo_ovf", overflow, 1);
        check("lifo_ovf_count", count, 16);
        step(1'b0, 1'b0, 8'd0);
        check("lifo_ovf_pulse", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("lifo_pop_dout", dout, 15 - i);
            check("lifo_pop_dvalid", dvalid, 1);
            if (i == 12) check("lifo_ae_3", almost_empty, 0);
            if (i == 13) check("lifo_ae_2", almost_empty, 1);
        end
        step(1'b0, 1'b1, 8'd0);
        check("lifo_udf", underflow, 1);
        check("lifo_udf_dout", dout, 0);
        check("lifo_udf_dvalid", dvalid, 0);
        check("lifo_udf_empty", empty, 1);

        // FIFO ordering and pointer wrap
        mode = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        check("fifo_mode_act", mode_act, 1);
        check("udf_pulse_clear", underflow, 0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
        check("fifo_full", full, 1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("fifo_pop_dout", dout, i);
        end
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'(50 + b * 10 + k));
            check("wrap_count10", count, 10);
            for (int k = 0; k < 10; k++) begin
                step(1'b0, 1'b1, 8'd0);
                check("wrap_dout", dout, 50 + b * 10 + k);
            end
        end
        check("wrap_count0", count, 0);
        check("wrap_empty", empty, 1);

        // LIFO replace-top
        mode = 1'b0;
        step(1'b0, 1'b0, 8'd0);
        check("lifo2_mode_act", mode_act, 0);
        step(1'b1, 1'b0, 8'd5);
        step(1'b1, 1'b0, 8'd6);
        step(1'b1, 1'b0, 8'd7);
        step(1'b1, 1'b1, 8'd9);
        check("repl_dout", dout, 7);
        check("repl_count", count, 3);
        check("repl_dvalid", dvalid, 1);
        step(1'b0, 1'b1, 8'd0);
        check("repl_pop1", dout, 9);
        step(1'b0, 1'b1, 8'd0);
        check("repl_pop2", dout, 6);
        step(1'b0, 1'b1, 8'd0);
        check("repl_pop3", dout, 5);

        // FIFO push+pop while full
        mode = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        check("dvalid_clear", dvalid, 0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b1, 8'd99);
        check("ff_rw_dout", dout, 0);
        check("ff_rw_ovf", overflow, 0);
        check("ff_rw_count", count, 16);
        check("ff_rw_full", full, 1);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("ff_drain", dout, i);
        end
        step(1'b0, 1'b1, 8'd0);
        check("ff_drain_last", dout, 99);

        // mode lock while occupied
        mode = 1'b0;
        step(1'b0, 1'b0, 8'd0);
        check("lock_lifo", mode_act, 0);
        step(1'b1, 1'b0, 8'd1);
        step(1'b1, 1'b0, 8'd2);
        step(1'b1, 1'b0, 8'd3);
        mode = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        check("lock_hold", mode_act, 0);
        step(1'b0, 1'b1, 8'd0);
        check("lock_pop1", dout, 3);
        step(1'b0, 1'b1, 8'd0);
        step(1'b0, 1'b1, 8'd0);
        check("lock_pop3", dout, 1);
        check("lock_still0", mode_act, 0);
        step(1'b0, 1'b0, 8'd0);
        check("lock_reload", mode_act, 1);
        step(1'b1, 1'b1, 8'd42);
        check("empty_rw_udf", underflow, 1);
        check("empty_rw_count", count, 1);
        check("empty_rw_dout", dout, 1);
        check("empty_rw_dvalid", dvalid, 0);
        step(1'b0, 1'b1, 8'd0);
        check("empty_rw_pop", dout, 42);

        // reset mid-burst
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(20 + i));
        check("pre_rst_count", count, 9);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'd77);
        rst = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_dvalid", dvalid, 0);
        step(1'b0, 1'b1, 8'd0);
        check("post_rst_udf", underflow, 1);
        check("post_rst_dvalid", dvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
